// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Rotates a one-hot stage enable across NUM_STAGES pipeline-less CPU stages
// (fetch/decode/execute/datamem/writeback for the default of five). Any active
// stage can be held by its stall_req bit. Instruction boundaries are the
// completion of the last stage; halt and single-step only take effect there,
// so an instruction in flight always finishes. Retired-instruction and
// stall-cycle counters are provided for debug and wrap silently.
//
// Ports:
//   sysclk        in   system clock, all state changes on its rising edge
//   reset         in   synchronous active-high reset
//   stall_req     in   [NUM_STAGES] per-stage hold, only the active bit matters
//   halt_req      in   level, stop at the next instruction boundary
//   step_mode     in   level, 1 = single-step, 0 = free-run
//   step_pulse    in   while halted in step mode, run one instruction
//   stage_en      out  [NUM_STAGES] one-hot active stage, zero when halted
//   stage_idx     out  [IDX_W] active stage index, NUM_STAGES-1 when halted
//   halted        out  high while halted
//   instr_done    out  registered pulse one cycle after retired_count changes
//   retired_count out  [CNT_WIDTH] completed instructions
//   stall_count   out  [CNT_WIDTH] cycles spent held by stall_req
//
// Handshake: stall_req is a plain level hold; a stage advances in every cycle
// it is active and its stall bit is low. There is no ready/valid pairing.
// -----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_WIDTH  = 32,
    parameter int IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  halt_req,
    input  logic                  step_mode,
    input  logic                  step_pulse,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  halted,
    output logic                  instr_done,
    output logic [CNT_WIDTH-1:0]  retired_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] FIRST_EN = NUM_STAGES'(1);
    localparam logic [NUM_STAGES-1:0] LAST_EN  = FIRST_EN << (NUM_STAGES - 1);

    state_t                  state_q,      state_d;
    logic [IDX_W-1:0]        stage_idx_q,  stage_idx_d;
    logic [NUM_STAGES-1:0]   stage_en_q,   stage_en_d;
    logic                    halted_q,     halted_d;
    logic                    primed_q,     primed_d;
    logic                    done_pend_q,  done_pend_d;
    logic                    instr_done_q, instr_done_d;
    logic [CNT_WIDTH-1:0]    retired_q,    retired_d;
    logic [CNT_WIDTH-1:0]    stall_cnt_q,  stall_cnt_d;

    always_comb begin
        state_d      = state_q;
        stage_idx_d  = stage_idx_q;
        stage_en_d   = stage_en_q;
        halted_d     = halted_q;
        primed_d     = primed_q;
        retired_d    = retired_q;
        stall_cnt_d  = stall_cnt_q;
        // done_pend marks the cycle retired_count changes; instr_done follows
        // it by one cycle so the two are never high together.
        done_pend_d  = 1'b0;
        instr_done_d = done_pend_q;

        case (state_q)
            S_RUN: begin
                if (stall_req[stage_idx_q]) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end else if (stage_idx_q != LAST_IDX) begin
                    stage_idx_d = stage_idx_q + 1'b1;
                    stage_en_d  = stage_en_q << 1;
                end else begin
                    // Reset parks the rotation on the last stage, so the very
                    // first boundary is not a real instruction and is skipped.
                    if (primed_q) begin
                        retired_d   = retired_q + 1'b1;
                        done_pend_d = 1'b1;
                    end
                    primed_d = 1'b1;
                    if (halt_req || step_mode) begin
                        state_d     = S_HALTED;
                        halted_d    = 1'b1;
                        stage_en_d  = '0;
                        stage_idx_d = LAST_IDX;
                    end else begin
                        stage_idx_d = '0;
                        stage_en_d  = FIRST_EN;
                    end
                end
            end

            S_HALTED: begin
                if ((step_mode && step_pulse) || (!step_mode && !halt_req)) begin
                    state_d     = S_RUN;
                    halted_d    = 1'b0;
                    stage_idx_d = '0;
                    stage_en_d  = FIRST_EN;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= S_RUN;
            stage_idx_q  <= LAST_IDX;
            stage_en_q   <= LAST_EN;
            halted_q     <= 1'b0;
            primed_q     <= 1'b0;
            done_pend_q  <= 1'b0;
            instr_done_q <= 1'b0;
            retired_q    <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            stage_idx_q  <= stage_idx_d;
            stage_en_q   <= stage_en_d;
            halted_q     <= halted_d;
            primed_q     <= primed_d;
            done_pend_q  <= done_pend_d;
            instr_done_q <= instr_done_d;
            retired_q    <= retired_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign stage_en      = stage_en_q;
    assign stage_idx     = stage_idx_q;
    assign halted        = halted_q;
    assign instr_done    = instr_done_q;
    assign retired_count = retired_q;
    assign stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Drives stage_sequencer (5 stages, 4-bit counters so wrap is reachable) and
// checks it against a behavioural model that tracks the active stage as an
// integer position, a halted flag and plain integer counters.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    localparam int N  = 5;
    localparam int CW = 4;
    localparam int IW = $clog2(N);
    localparam int VW = N + IW + 2 + 2 * CW;
    localparam int CMOD = 1 << CW;

    // ---------------- clock / reset ----------------
    logic          sysclk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  stall_req = '0;
    logic          halt_req = 1'b0;
    logic          step_mode = 1'b0;
    logic          step_pulse = 1'b0;
    logic [N-1:0]  stage_en;
    logic [IW-1:0] stage_idx;
    logic          halted;
    logic          instr_done;
    logic [CW-1:0] retired_count;
    logic [CW-1:0] stall_count;

    always #5 sysclk = ~sysclk;

    stage_sequencer #(.NUM_STAGES(N), .CNT_WIDTH(CW)) dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .stall_req     (stall_req),
        .halt_req      (halt_req),
        .step_mode     (step_mode),
        .step_pulse    (step_pulse),
        .stage_en      (stage_en),
        .stage_idx     (stage_idx),
        .halted        (halted),
        .instr_done    (instr_done),
        .retired_count (retired_count),
        .stall_count   (stall_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int m_pos;
    bit m_halted;
    bit m_primed;
    bit m_pend;
    bit m_done;
    int m_ret;
    int m_stall;
    logic [CW-1:0] exp_q[$];

    logic [VW-1:0] act_vec;
    assign act_vec = {stage_en, stage_idx, halted, instr_done, retired_count, stall_count};

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] en;
        en = m_halted ? '0 : (N'(1) << m_pos);
        return {en, IW'(m_pos), m_halted, m_done, CW'(m_ret), CW'(m_stall)};
    endfunction

    task automatic model_step(input logic [N-1:0] s, input logic h, input logic sm,
                              input logic sp, input logic rst);
        if (rst) begin
            m_pos = N - 1; m_halted = 0; m_primed = 0; m_pend = 0; m_done = 0;
            m_ret = 0; m_stall = 0;
            exp_q.delete();
        end else begin
            m_done = m_pend;
            m_pend = 0;
            if (!m_halted) begin
                if (s[m_pos]) begin
                    m_stall = (m_stall + 1) % CMOD;
                end else if (m_pos < N - 1) begin
                    m_pos = m_pos + 1;
                end else begin
                    if (m_primed) begin
                        m_ret = (m_ret + 1) % CMOD;
                        m_pend = 1;
                        exp_q.push_back(CW'(m_ret));
                    end
                    m_primed = 1;
                    if (h || sm) m_halted = 1;
                    else m_pos = 0;
                end
            end else if ((sm && sp) || (!sm && !h)) begin
                m_halted = 0;
                m_pos = 0;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick(input logic [N-1:0] s, input logic h, input logic sm,
                        input logic sp, input logic rst);
        stall_req = s; halt_req = h; step_mode = sm; step_pulse = sp; reset = rst;
        @(posedge sysclk);
        model_step(s, h, sm, sp, rst);
        @(negedge sysclk);
    endtask

    // ---------------- scoreboard: each instr_done pulse retires one entry ----------------
    always @(negedge sysclk) begin
        if (instr_done === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL done_sb: instr_done with no expected retire, retired_count=%0d", retired_count);
            end else begin
                logic [CW-1:0] e;
                e = exp_q.pop_front();
                if (retired_count !== e) begin
                    n_err++;
                    $display("FAIL done_sb: retired_count=%0d expected %0d", retired_count, e);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        tick('0, 0, 0, 0, 1);
        tick('0, 0, 0, 0, 1);
        n_vec++;
        if (act_vec !== {5'b10000, 3'd4, 1'b0, 1'b0, 4'd0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_values: got %h expected %h", act_vec, {5'b10000, 3'd4, 1'b0, 1'b0, 4'd0, 4'd0});
        end
        n_vec++;
        if (act_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_model: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_free_run();
        logic [N-1:0] seq [6];
        seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        for (int i = 0; i < 30; i++) begin
            tick('0, 0, 0, 0, 0);
            if (i < 6) begin
                n_vec++;
                if (stage_en !== seq[i]) begin
                    n_err++;
                    $display("FAIL free_run_seq[%0d]: stage_en=%b expected %b", i, stage_en, seq[i]);
                end
            end
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL free_run cyc %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_stall();
        logic [CW-1:0] s0;
        for (int i = 0; i < 10 && stage_idx !== 3'd2; i++) tick('0, 0, 0, 0, 0);
        n_vec++;
        if (stage_idx !== 3'd2) begin
            n_err++;
            $display("FAIL stall_reach: stage_idx=%0d expected 2", stage_idx);
        end
        s0 = stall_count;
        for (int i = 0; i < 3; i++) begin
            tick(5'b00100, 0, 0, 0, 0);
            n_vec++;
            if (stage_en !== 5'b00100 || act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL stall_hold cyc %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        tick('0, 0, 0, 0, 0);
        n_vec++;
        if (stage_en !== 5'b01000 || CW'(stall_count - s0) !== CW'(3)) begin
            n_err++;
            $display("FAIL stall_release: stage_en=%b delta=%0d expected 01000/3", stage_en, CW'(stall_count - s0));
        end
    endtask

    task automatic test_halt();
        int n;
        for (int i = 0; i < 10 && stage_idx !== 3'd1; i++) tick('0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 10 && halted !== 1'b1; i++) begin
            tick('0, 1, 0, 0, 0);
            n++;
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL halt_enter cyc %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        n_vec++;
        if (n !== 4 || halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_latency: cycles=%0d halted=%b expected 4/1", n, halted);
        end
        for (int i = 0; i < 3; i++) begin
            tick(5'b11111, 1, 0, 0, 0);
            n_vec++;
            if (stage_en !== '0 || act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL halt_hold cyc %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        tick('0, 0, 0, 0, 0);
        n_vec++;
        if (stage_en !== 5'b00001 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL halt_resume: stage_en=%b halted=%b expected 00001/0", stage_en, halted);
        end
    endtask

    task automatic test_single_step();
        logic [CW-1:0] r0;
        for (int i = 0; i < 10 && halted !== 1'b1; i++) tick('0, 0, 1, 0, 0);
        n_vec++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL step_enter: halted=%b expected 1", halted);
        end
        r0 = retired_count;
        for (int p = 0; p < 3; p++) begin
            tick('0, 0, 1, 1, 0);
            for (int j = 0; j < 9; j++) begin
                tick('0, 0, 1, (j == 2) ? 1'b1 : 1'b0, 0);
                n_vec++;
                if (act_vec !== exp_vec()) begin
                    n_err++;
                    $display("FAIL step p%0d cyc %0d: got %h expected %h", p, j, act_vec, exp_vec());
                end
            end
            n_vec++;
            if (halted !== 1'b1) begin
                n_err++;
                $display("FAIL step_gap p%0d: halted=%b expected 1", p, halted);
            end
        end
        n_vec++;
        if (CW'(retired_count - r0) !== CW'(3)) begin
            n_err++;
            $display("FAIL step_count: delta=%0d expected 3", CW'(retired_count - r0));
        end
        tick('0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_stall();
        for (int i = 0; i < 10 && stage_idx !== 3'd3; i++) tick('0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick(5'b01000, 0, 0, 0, 0);
        tick(5'b01000, 1, 1, 1, 1);
        n_vec++;
        if (act_vec !== {5'b10000, 3'd4, 1'b0, 1'b0, 4'd0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_mid_stall: got %h expected %h", act_vec, {5'b10000, 3'd4, 1'b0, 1'b0, 4'd0, 4'd0});
        end
        for (int i = 0; i < 12; i++) begin
            tick('0, 0, 0, 0, 0);
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL post_reset cyc %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic h, sm;
        logic [N-1:0] s;
        h = 0; sm = 0;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++) s[b] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) h = ~h;
            if ($urandom_range(0, 39) == 0) sm = ~sm;
            tick(s, h, sm, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_wrap();
        int pulses, last;
        pulses = 0; last = -1;
        for (int i = 0; i < 100; i++) begin
            tick('0, 0, 0, 0, 0);
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL wrap cyc %0d: got %h expected %h", i, act_vec, exp_vec());
            end
            if (instr_done === 1'b1) begin
                if (last >= 0) begin
                    n_vec++;
                    if (i - last !== 5) begin
                        n_err++;
                        $display("FAIL wrap_gap: gap=%0d expected 5", i - last);
                    end
                end
                last = i;
                pulses++;
            end
        end
        n_vec++;
        if (pulses < 17) begin
            n_err++;
            $display("FAIL wrap_pulses: pulses=%0d expected at least 17", pulses);
        end
        n_vec++;
        if (exp_q.size() > 1) begin
            n_err++;
            $display("FAIL sb_drain: %0d retires never pulsed, expected at most 1 pending", exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_halt();
        test_single_step();
        test_reset_mid_stall();
        test_random();
        test_reset();
        tick('0, 0, 0, 0, 0);
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
